// File: rtl/umips_pkg.sv
// Shared constants and types for the umips register file.
//   REG_ZERO / REG_SP / REG_LO : architectural register indices
//   SP_RESET                   : stack-pointer value loaded by the init sweep
//   rf_state_t                 : register-file control state (init sweep / normal run)
package umips_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;

  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned REG_SP   = 29;
  localparam int unsigned REG_LO   = 8;

  localparam logic [31:0] SP_RESET = 32'h00003FF4;

  typedef enum logic [0:0] {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_t;

endpackage

// File: rtl/umips_rf_read_port.sv
// One combinational read port of the umips register file.
//   run   : 1 when the file is out of its init sweep; 0 forces rd to zero
//   ra    : read address
//   rword : stored word at ra, supplied by the storage array
//   we0/wa0/wd0, we1/wa1/wd1 : the two write ports, used for same-cycle forwarding
//   rd    : read data (register 0 always reads as zero, even when forwarded)
module umips_rf_read_port
  import umips_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned BYPASS = 1
) (
  input  logic              run,
  input  logic [ADDR_W-1:0] ra,
  input  logic [DATA_W-1:0] rword,
  input  logic              we0,
  input  logic [ADDR_W-1:0] wa0,
  input  logic [DATA_W-1:0] wd0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd1,
  output logic [DATA_W-1:0] rd
);

  localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(REG_ZERO);

  always_comb begin
    rd = '0;
    if (run && (ra != ZeroAddr)) begin
      // Port 1 wins address conflicts at the write, so it must win the forward too.
      if ((BYPASS != 0) && we1 && (wa1 == ra)) begin
        rd = wd1;
      end else if ((BYPASS != 0) && we0 && (wa0 == ra)) begin
        rd = wd0;
      end else begin
        rd = rword;
      end
    end
  end

endmodule

// File: rtl/umips_regfile_mp.sv
// Multi-port general-purpose register file for the umips core.
//   clk   : clock, all state on the rising edge
//   rst   : synchronous active-low reset; restarts the init sweep
//   we0/wa0/wd0 : write port 0 (EX/ALU)
//   we1/wa1/wd1 : write port 1 (load/MEM), wins same-address conflicts
//   ra    : NUM_RD packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd    : NUM_RD packed read data, port k at [k*DATA_W +: DATA_W]
//   tap   : stored value of regs[TAP_IDX] (LO), never forwarded
//   ready : 1 once every entry has been written by the init sweep
// Storage has no reset; after reset the sweep clears one entry per cycle
// (SP_IDX gets SP_INIT) so no wide reset fan-out is needed.
module umips_regfile_mp
  import umips_pkg::*;
#(
  parameter int unsigned        DATA_W  = DATA_W_DEF,
  parameter int unsigned        ADDR_W  = ADDR_W_DEF,
  parameter int unsigned        NUM_RD  = 2,
  parameter int unsigned        BYPASS  = 1,
  parameter int unsigned        SP_IDX  = REG_SP,
  parameter logic [DATA_W-1:0]  SP_INIT = DATA_W'(SP_RESET),
  parameter int unsigned        TAP_IDX = REG_LO
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic [DATA_W-1:0]        wd0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic [DATA_W-1:0]        wd1,
  input  logic [NUM_RD*ADDR_W-1:0] ra,
  output logic [NUM_RD*DATA_W-1:0] rd,
  output logic [DATA_W-1:0]        tap,
  output logic                     ready
);

  localparam int unsigned       Depth    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(REG_ZERO);
  localparam logic [ADDR_W-1:0] SpAddr   = ADDR_W'(SP_IDX);
  localparam logic [ADDR_W-1:0] TapAddr  = ADDR_W'(TAP_IDX);

  logic [DATA_W-1:0] regs [Depth];

  rf_state_t         state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              run;
  logic [DATA_W-1:0] init_word;

  assign run       = (state_q == RF_RUN);
  assign init_word = (cnt_q == SpAddr) ? SP_INIT : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    if (state_q == RF_INIT) begin
      cnt_d = cnt_q + 1'b1;
      // The edge that writes the last entry also leaves INIT.
      if (&cnt_q) begin
        state_d = RF_RUN;
        ready_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RF_INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  // Storage: sweep writes during INIT, port writes during RUN; port 1 is
  // assigned last so it wins a same-address conflict.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state_q == RF_INIT) begin
        regs[cnt_q] <= init_word;
      end else begin
        if (we0 && (wa0 != ZeroAddr)) begin
          regs[wa0] <= wd0;
        end
        if (we1 && (wa1 != ZeroAddr)) begin
          regs[wa1] <= wd1;
        end
      end
    end
  end

  assign tap   = run ? regs[TapAddr] : '0;
  assign ready = ready_q;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra_k;
    assign ra_k = ra[k*ADDR_W +: ADDR_W];

    umips_rf_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .BYPASS (BYPASS)
    ) u_rd (
      .run   (run),
      .ra    (ra_k),
      .rword (regs[ra_k]),
      .we0   (we0),
      .wa0   (wa0),
      .wd0   (wd0),
      .we1   (we1),
      .wa1   (wa1),
      .wd1   (wd1),
      .rd    (rd[k*DATA_W +: DATA_W])
    );
  end

endmodule
